vr_gen: RTL
===========

VR_GEN -- requirements
Module: vr_gen

Interface
REQ-001 SHALL have parameter TEETH, default 60, meaning wheel tooth positions per revolution, missing teeth included.
REQ-002 SHALL have parameter GAP, default 2, meaning missing teeth, range 1..3, GAP < TEETH-1.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  meaning run request; high generates the wheel, low stops it.
REQ-006 SHALL have port cfg_valid  input  1  meaning cfg_presc/cfg_period are offered.
REQ-007 SHALL have port cfg_ready  output  1  meaning a configuration can be accepted.
REQ-008 SHALL have port cfg_presc  input  8  meaning prescaler; tick every cfg_presc+1 clk.
REQ-009 SHALL have port cfg_period  input  16  meaning ticks per normal tooth.
REQ-010 SHALL have port vr_out  output  1  meaning the generated tooth signal, driven to the hwag vr_in input.
REQ-011 SHALL have port tooth  output  8  meaning current tooth index, 0..TEETH-GAP-1.
REQ-012 SHALL have port sync  output  1  meaning a one-clk pulse at the start of tooth 0.
REQ-013 SHALL have port running  output  1  meaning the state is RUN.

Function
REQ-014 SHALL implement states IDLE and RUN.
REQ-015 SHALL transfer a configuration on a clk where cfg_valid and cfg_ready are both high, into the pending register.
REQ-016 SHALL drive cfg_ready = !pending_full.
REQ-017 SHALL, in IDLE, copy pending into active in the clk after the transfer and clear pending_full.
REQ-018 SHALL, in RUN, copy pending into active only at the revolution boundary (tooth wraps to 0); a transfer on the boundary clk applies at the next boundary.
REQ-019 SHALL clamp an active period below 2 to 2.
REQ-020 SHALL move IDLE->RUN when en=1 and an active config exists; on that clk tooth=0, phase=0, prescaler=0, sync=1.
REQ-021 SHALL move RUN->IDLE on the clk en=0 is sampled; counters clear, vr_out=0, tooth=0.
REQ-022 SHALL advance phase by 1 per tick, from 0 to top.
REQ-023 SHALL use top = period-1 for normal teeth and top = period*(GAP+1)-1 for tooth TEETH-GAP-1; the product is 20 bits wide, with no truncation.
REQ-024 SHALL, when phase==top on a tick, set phase=0 and vr_out=0, and advance the tooth, wrapping TEETH-GAP-1 -> 0 with sync=1.
REQ-025 SHALL set vr_out=1 on the tick where phase==top>>1, with phase incrementing on that tick.
REQ-026 SHALL keep vr_out and tooth registered and make them change only on tick clks.
REQ-027 SHALL assert sync for exactly one clk per revolution.
REQ-028 SHALL give en=0 priority over a same-clk boundary.
REQ-029 SHALL accept cfg transfers in either state.

Reset
REQ-030 SHALL, with rst=0, immediately force IDLE and clear pending_full and active-valid.
REQ-031 SHALL, with rst=0, immediately force vr_out=0, tooth=0, sync=0, running=0, cfg_ready=1, and every counter to 0.
REQ-032 SHALL, when rst asserts mid-revolution, leave no partial state; after release the block stays IDLE until a new configuration arrives.

Structure
REQ-033 SHALL take TEETH/GAP defaults, counter width 20 and the state enum from the shared package hwag_pkg.
REQ-034 SHALL put the prescaler tick generator in sub-module vr_presc (clk, rst, clear, presc, tick).

Verification
REQ-035 SHALL cover presc=3, period=64, en=1: normal tooth 256 clk with vr high the last 128; tooth 57 768 clk with vr rising at phase 95; revolution 15360 clk; one sync per revolution.
REQ-036 SHALL cover a cfg transfer (period=32) at tooth 10: cfg_ready low until the boundary; the new 128-clk teeth begin exactly at the tooth-0 sync.
REQ-037 SHALL cover en=0 at tooth 20 mid-phase: next clk vr_out=0, tooth=0, running=0; with en=1 again, restart at tooth 0 with sync.
REQ-038 SHALL cover period=0 or 1 loaded: behaves as period=2; vr toggles each tick.
REQ-039 SHALL cover rst low during tooth 57 high phase: outputs cleared asynchronously; after release en=1 gives no activity until a config is transferred.
REQ-040 SHALL cover a loop-back into hwag with HWATHNB=57, HWATHVL=2: hwag locks on sync, with no pcnt overflow interrupt.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared definitions for the crank-wheel (HWAG) blocks: wheel geometry defaults,
// counter width, generator states and small arithmetic helpers.
package hwag_pkg;

  localparam int TEETH_DEF = 60;
  localparam int GAP_DEF   = 2;
  localparam int CNT_W     = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vr_state_t;

  // Periods of 0 or 1 cannot produce a low and a high half, so they run as 2.
  function automatic logic [15:0] clamp_period(input logic [15:0] period);
    return (period < 16'd2) ? 16'd2 : period;
  endfunction

  // Last phase value of a tooth; the gap tooth spans the missing teeth too.
  function automatic logic [CNT_W-1:0] tooth_top(input logic [15:0]      period,
                                                 input logic             gap_tooth,
                                                 input logic [CNT_W-1:0] gap_mul);
    logic [CNT_W-1:0] p;
    p = CNT_W'(period);
    return gap_tooth ? (p * gap_mul) - CNT_W'(1) : p - CNT_W'(1);
  endfunction

endpackage

// File: rtl/vr_presc.sv
// Prescaler for the wheel generator: one tick every presc+1 clocks, held at
// zero while clear is high so a run always starts from a known count.
module vr_presc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] cnt;

  assign tick = !clear && (cnt == presc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (clear || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/vr_gen.sv
// Variable-reluctance wheel generator: TEETH-GAP teeth per revolution with a
// long gap tooth, configured through a one-deep pending register.
//   state   | meaning
//   ST_IDLE | stopped, outputs low, pending config copied to active at once
//   ST_RUN  | wheel running, pending config applied only at tooth-0 wrap
module vr_gen
  import hwag_pkg::*;
#(
  parameter int TEETH = TEETH_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_presc,
  input  logic [15:0] cfg_period,
  output logic        vr_out,
  output logic [7:0]  tooth,
  output logic        sync,
  output logic        running
);

  localparam logic [7:0]       LAST    = 8'(TEETH - GAP - 1);
  localparam logic [CNT_W-1:0] GAP_MUL = CNT_W'(GAP + 1);

  vr_state_t        state, state_nx;
  logic             pend_full, act_valid;
  logic [7:0]       pend_presc, act_presc;
  logic [15:0]      pend_period, act_period;
  logic [CNT_W-1:0] phase, top, half;
  logic             tick, last_tooth, xfer;
  logic             start, stop, load_act, presc_clear;

  assign cfg_ready  = !pend_full;
  assign running    = (state == ST_RUN);
  assign xfer       = cfg_valid && cfg_ready;
  assign last_tooth = (tooth == LAST);
  assign top        = tooth_top(act_period, last_tooth, GAP_MUL);
  assign half       = top >> 1;

  vr_presc u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .presc (act_presc),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // The prescaler is cleared whenever not running, including the stop clock,
  // so a same-clock boundary can never fire once en has dropped.
  always_comb begin
    state_nx    = state;
    start       = 1'b0;
    stop        = 1'b0;
    load_act    = 1'b0;
    presc_clear = 1'b1;
    case (state)
      ST_IDLE: begin
        load_act = pend_full;
        if (en && act_valid) begin
          state_nx = ST_RUN;
          start    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nx = ST_IDLE;
          stop     = 1'b1;
        end else begin
          presc_clear = 1'b0;
          load_act    = pend_full && tick && (phase == top) && last_tooth;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full   <= 1'b0;
      pend_presc  <= 8'd0;
      pend_period <= 16'd0;
      act_valid   <= 1'b0;
      act_presc   <= 8'd0;
      act_period  <= 16'd0;
      phase       <= '0;
      tooth       <= 8'd0;
      vr_out      <= 1'b0;
      sync        <= 1'b0;
    end else begin
      if (xfer) begin
        pend_full   <= 1'b1;
        pend_presc  <= cfg_presc;
        pend_period <= cfg_period;
      end else if (load_act) begin
        pend_full <= 1'b0;
      end

      if (load_act) begin
        act_valid  <= 1'b1;
        act_presc  <= pend_presc;
        act_period <= clamp_period(pend_period);
      end

      sync <= 1'b0;
      if (start || stop) begin
        phase  <= '0;
        tooth  <= 8'd0;
        vr_out <= 1'b0;
        sync   <= start;
      end else if (tick) begin
        if (phase == top) begin
          phase  <= '0;
          vr_out <= 1'b0;
          if (last_tooth) begin
            tooth <= 8'd0;
            sync  <= 1'b1;
          end else begin
            tooth <= tooth + 8'd1;
          end
        end else begin
          phase <= phase + CNT_W'(1);
          if (phase == half) vr_out <= 1'b1;
        end
      end
    end
  end

endmodule
